// File: rtl/clarvi_alu_sequencer_if.sv
// clarvi_alu_sequencer_if: decoded-instruction types plus the request/response/ALU
// bundle shared by the sequencer (slave) and its environment (master).
package clarvi_alu_pkg;
    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SL, OP_SRL, OP_SRA, OP_XOR, OP_OR, OP_AND,
        OP_SLT, OP_SLTU, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR
    } op_t;
    typedef struct packed {
        op_t        op;
        logic       is32_bit_op;
        logic [1:0] instr_part;
        logic       immediate_used;
    } instr_t;
endpackage

interface clarvi_alu_sequencer_if;
    import clarvi_alu_pkg::*;
    logic        req_valid;
    logic        req_ready;
    instr_t      req_instr;
    logic [63:0] req_rs1;
    logic [63:0] req_rs2;
    instr_t      alu_instr;
    logic [15:0] alu_rs1;
    logic [15:0] alu_rs2;
    logic        alu_stall;
    logic [15:0] alu_result;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_result;
    logic        busy;
    modport slave (
        input  req_valid, req_instr, req_rs1, req_rs2, alu_result, resp_ready,
        output req_ready, alu_instr, alu_rs1, alu_rs2, alu_stall, resp_valid, resp_result, busy
    );
    modport master (
        output req_valid, req_instr, req_rs1, req_rs2, alu_result, resp_ready,
        input  req_ready, alu_instr, alu_rs1, alu_rs2, alu_stall, resp_valid, resp_result, busy
    );
endinterface

// File: rtl/clarvi_alu_sequencer.sv
// clarvi_alu_sequencer: runs a 64-bit op through a 16-bit ALU as four parts, ordering
// parts so carries flow upward and compares/right shifts flow downward.
module clarvi_alu_sequencer
    import clarvi_alu_pkg::*;
(
    input logic clock,
    input logic reset,
    clarvi_alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  s_q, s_d;
    instr_t      instr_q, instr_d;
    logic [63:0] rs1_q, rs1_d, rs2_q, rs2_d, result_q, result_d;
    logic        is_sr, is_shift, is32, descending;
    logic [1:0]  part;
    logic [5:0]  base, shamt;
    instr_t      alu_instr_c;
    always_comb begin
        is_sr      = instr_q.op inside {OP_SRL, OP_SRA};
        is_shift   = is_sr || instr_q.op == OP_SL;
        is32       = instr_q.is32_bit_op && (is_shift || instr_q.op inside {OP_ADD, OP_SUB});
        descending = instr_q.op inside {OP_SLT, OP_SLTU} || (is_sr && !is32);
        // 32-bit right shifts go high-to-low within each word: parts 1,0,3,2
        part       = (is_sr && is32) ? (s_q ^ 2'b01) : descending ? ~s_q : s_q;
        base       = {part, 4'b0};
        shamt      = {rs2_q[5] && !is32, rs2_q[4:0]};
        alu_instr_c                = instr_q;
        alu_instr_c.is32_bit_op    = is32;
        alu_instr_c.instr_part     = part;
        alu_instr_c.immediate_used = 1'b0;
    end
    assign bus.alu_instr   = alu_instr_c;
    assign bus.alu_rs1     = rs1_q[base +: 16];
    assign bus.alu_rs2     = is_shift ? {10'b0, shamt} : rs2_q[base +: 16];
    assign bus.alu_stall   = state_q != EXEC;
    assign bus.req_ready   = state_q == IDLE;
    assign bus.resp_valid  = state_q == DONE;
    assign bus.resp_result = result_q;
    assign bus.busy        = state_q != IDLE;
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        instr_d  = instr_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: if (bus.req_valid) begin
                instr_d  = bus.req_instr;
                rs1_d    = bus.req_rs1;
                rs2_d    = bus.req_rs2;
                result_d = '0;
                s_d      = 2'd0;
                state_d  = EXEC;
            end
            EXEC: begin
                result_d[base +: 16] = bus.alu_result;
                s_d                  = s_q + 2'd1;
                state_d              = (s_q == 2'd3) ? DONE : EXEC;
            end
            DONE: state_d = bus.resp_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            s_q      <= 2'd0;
            instr_q  <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            instr_q  <= instr_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_clarvi_alu_sequencer.sv
// tb_clarvi_alu_sequencer: drives directed and random ops; the ALU stub serves slices of a
// full-width reference result so ordering, slicing and assembly are all observable.
module tb_clarvi_alu_sequencer;
    import clarvi_alu_pkg::*;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    logic [63:0] golden = '0;
    logic [63:0] last_result = '0;
    always #5 clock = ~clock;
    clarvi_alu_sequencer_if bus();
    clarvi_alu_sequencer dut (.clock(clock), .reset(reset), .bus(bus));
    assign bus.alu_result = golden[{bus.alu_instr.instr_part, 4'b0} +: 16];

    function automatic logic [63:0] sx(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    function automatic logic [63:0] model(input op_t op, input logic w, input logic [63:0] a, input logic [63:0] b);
        logic [31:0] sra32;
        sra32 = $signed(a[31:0]) >>> b[4:0];
        case (op)
            OP_ADD:  return w ? sx(a[31:0] + b[31:0]) : a + b;
            OP_SUB:  return w ? sx(a[31:0] - b[31:0]) : a - b;
            OP_SL:   return w ? sx(a[31:0] << b[4:0]) : a << b[5:0];
            OP_SRL:  return w ? sx(a[31:0] >> b[4:0]) : a >> b[5:0];
            OP_SRA:  return w ? sx(sra32) : 64'($signed(a) >>> b[5:0]);
            OP_XOR:  return a ^ b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_SLT:  return {63'b0, $signed(a) < $signed(b)};
            OP_SLTU: return {63'b0, a < b};
            OP_LUI:  return b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [1:0] exp_part(input op_t op, input logic w, input int k);
        if (op inside {OP_SRL, OP_SRA} && w) return (k == 0) ? 2'd1 : (k == 1) ? 2'd0 : (k == 2) ? 2'd3 : 2'd2;
        if (op inside {OP_SLT, OP_SLTU, OP_SRL, OP_SRA}) return 2'(3 - k);
        return 2'(k);
    endfunction

    task automatic run_op(input op_t op, input logic w, input logic [63:0] a, input logic [63:0] b, input int hold, input string tag);
        instr_t ins;
        logic [1:0] p;
        logic [15:0] e2;
        logic w_eff;
        golden = model(op, w, a, b);
        w_eff = w && (op inside {OP_ADD, OP_SUB, OP_SL, OP_SRL, OP_SRA});
        ins = '{op: op, is32_bit_op: w, instr_part: 2'($urandom), immediate_used: 1'($urandom)};
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_instr = ins; bus.req_rs1 = a; bus.req_rs2 = b; bus.resp_ready = 1'b0;
        vectors++;
        if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL %s req_ready_idle got %b want 1", tag, bus.req_ready); end
        @(negedge clock);
        bus.req_valid = 1'b0; bus.req_rs1 = {$urandom, $urandom}; bus.req_rs2 = {$urandom, $urandom};
        bus.req_instr = instr_t'(9'($urandom));
        for (int k = 0; k < 4; k++) begin
            p = exp_part(op, w, k);
            e2 = (op inside {OP_SL, OP_SRL, OP_SRA}) ? {10'b0, w ? {1'b0, b[4:0]} : b[5:0]} : b[{p, 4'b0} +: 16];
            vectors++;
            if (bus.alu_instr.instr_part !== p) begin miscompares++; $display("FAIL %s part step%0d got %0d want %0d", tag, k, bus.alu_instr.instr_part, p); end
            vectors++;
            if (bus.alu_rs1 !== a[{p, 4'b0} +: 16]) begin miscompares++; $display("FAIL %s alu_rs1 step%0d got %h want %h", tag, k, bus.alu_rs1, a[{p, 4'b0} +: 16]); end
            vectors++;
            if (bus.alu_rs2 !== e2) begin miscompares++; $display("FAIL %s alu_rs2 step%0d got %h want %h", tag, k, bus.alu_rs2, e2); end
            vectors++;
            if ({bus.alu_stall, bus.resp_valid, bus.busy} !== 3'b001) begin miscompares++; $display("FAIL %s exec_flags step%0d got %b want 001", tag, k, {bus.alu_stall, bus.resp_valid, bus.busy}); end
            vectors++;
            if ({bus.alu_instr.op, bus.alu_instr.is32_bit_op, bus.alu_instr.immediate_used} !== {op, w_eff, 1'b0}) begin
                miscompares++; $display("FAIL %s alu_instr step%0d got %h want %h", tag, k, {bus.alu_instr.op, bus.alu_instr.is32_bit_op, bus.alu_instr.immediate_used}, {op, w_eff, 1'b0});
            end
            if (k < 3) @(negedge clock);
        end
        @(negedge clock);
        last_result = bus.resp_result;
        vectors++;
        if (bus.resp_valid !== 1'b1 || bus.resp_result !== golden) begin miscompares++; $display("FAIL %s result got %b/%h want 1/%h", tag, bus.resp_valid, bus.resp_result, golden); end
        vectors++;
        if ({bus.req_ready, bus.alu_stall, bus.busy} !== 3'b011) begin miscompares++; $display("FAIL %s done_flags got %b want 011", tag, {bus.req_ready, bus.alu_stall, bus.busy}); end
        for (int h = 0; h < hold; h++) begin
            bus.req_valid = 1'b1; bus.req_instr = ins;
            @(negedge clock);
            vectors++;
            if ({bus.resp_valid, bus.req_ready, bus.alu_stall} !== 3'b101 || bus.resp_result !== golden) begin
                miscompares++; $display("FAIL %s hold%0d got %b/%h want 101/%h", tag, h, {bus.resp_valid, bus.req_ready, bus.alu_stall}, bus.resp_result, golden);
            end
        end
        bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
        @(negedge clock);
        vectors++;
        if ({bus.req_ready, bus.resp_valid, bus.busy, bus.alu_stall} !== 4'b1001) begin miscompares++; $display("FAIL %s back_idle got %b want 1001", tag, {bus.req_ready, bus.resp_valid, bus.busy, bus.alu_stall}); end
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        vectors++;
        if ({bus.req_ready, bus.resp_valid, bus.alu_stall, bus.busy} !== 4'b1010) begin miscompares++; $display("FAIL reset_flags got %b want 1010", {bus.req_ready, bus.resp_valid, bus.alu_stall, bus.busy}); end
        vectors++;
        if (bus.resp_result !== 64'd0 || bus.alu_rs1 !== 16'd0 || bus.alu_rs2 !== 16'd0) begin miscompares++; $display("FAIL reset_data got %h/%h/%h want 0", bus.resp_result, bus.alu_rs1, bus.alu_rs2); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if ({bus.req_ready, bus.resp_valid, bus.alu_stall, bus.busy} !== 4'b1010) begin miscompares++; $display("FAIL post_reset_flags got %b want 1010", {bus.req_ready, bus.resp_valid, bus.alu_stall, bus.busy}); end
    endtask

    task automatic test_directed();
        run_op(OP_ADD, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, "add64");
        vectors++;
        if (last_result !== 64'h0000_0001_0000_0000) begin miscompares++; $display("FAIL add64_const got %h want 0000000100000000", last_result); end
        run_op(OP_ADD, 1'b1, 64'h7FFF_FFFF, 64'd1, 0, "add32");
        vectors++;
        if (last_result !== 64'hFFFF_FFFF_8000_0000) begin miscompares++; $display("FAIL add32_const got %h want ffffffff80000000", last_result); end
        run_op(OP_SLT, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, "slt");
        vectors++;
        if (last_result !== 64'd1) begin miscompares++; $display("FAIL slt_const got %h want 1", last_result); end
        run_op(OP_SLTU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, "sltu");
        vectors++;
        if (last_result !== 64'd0) begin miscompares++; $display("FAIL sltu_const got %h want 0", last_result); end
        run_op(OP_SRA, 1'b1, 64'h8000_0000, 64'h24, 0, "sra32");
        vectors++;
        if (last_result !== 64'hFFFF_FFFF_F800_0000) begin miscompares++; $display("FAIL sra32_const got %h want fffffffff8000000", last_result); end
        run_op(OP_XOR, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000, 0, "xor_is32_ignored");
    endtask

    task automatic test_backpressure();
        run_op(OP_SUB, 1'b0, 64'h0001_0000_0000_0000, 64'd3, 3, "backpressure");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            run_op(op_t'(5'($urandom_range(0, 13))), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 2)), "random");
    endtask

    task automatic test_reset_abort(input int cycles, input string tag);
        golden = model(OP_ADD, 1'b0, 64'd1, 64'd2);
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_instr = '{op: OP_ADD, is32_bit_op: 1'b0, instr_part: 2'd0, immediate_used: 1'b0};
        bus.req_rs1 = 64'd1; bus.req_rs2 = 64'd2; bus.resp_ready = 1'b0;
        @(negedge clock);
        bus.req_valid = 1'b0;
        repeat (cycles) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({bus.req_ready, bus.resp_valid, bus.alu_stall, bus.busy} !== 4'b1010 || bus.resp_result !== 64'd0) begin
            miscompares++; $display("FAIL %s abort got %b/%h want 1010/0", tag, {bus.req_ready, bus.resp_valid, bus.alu_stall, bus.busy}, bus.resp_result);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            vectors++;
            if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL %s no_resp cyc%0d got %b%b want 00", tag, i, bus.resp_valid, bus.busy); end
        end
        run_op(OP_ADD, 1'b0, 64'd5, 64'd7, 0, "after_reset");
        vectors++;
        if (last_result !== 64'd12) begin miscompares++; $display("FAIL %s add_5_7 got %h want c", tag, last_result); end
    endtask

    task automatic test_back_to_back();
        int t[4];
        int n = 0;
        golden = model(OP_OR, 1'b0, 64'h00F0_0F00_F000_000F, 64'h1111_2222_3333_4444);
        bus.req_instr = '{op: OP_OR, is32_bit_op: 1'b0, instr_part: 2'd0, immediate_used: 1'b0};
        bus.req_rs1 = 64'h00F0_0F00_F000_000F; bus.req_rs2 = 64'h1111_2222_3333_4444;
        @(negedge clock);
        bus.req_valid = 1'b1; bus.resp_ready = 1'b1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            if (bus.req_ready) begin t[n] = c; n++; end
            if (bus.resp_valid) begin
                vectors++;
                if (bus.resp_result !== golden) begin miscompares++; $display("FAIL b2b result got %h want %h", bus.resp_result, golden); end
            end
            if (n < 4) @(negedge clock);
        end
        bus.req_valid = 1'b0;
        vectors++;
        if (n != 4) begin miscompares++; $display("FAIL b2b accepts got %0d want 4", n); end
        else for (int i = 1; i < 4; i++) begin
            vectors++;
            if (t[i] - t[i-1] != 6) begin miscompares++; $display("FAIL b2b gap%0d got %0d want 6", i, t[i] - t[i-1]); end
        end
        repeat (6) @(negedge clock);
        vectors++;
        if ({bus.req_ready, bus.busy} !== 2'b10) begin miscompares++; $display("FAIL b2b drain got %b want 10", {bus.req_ready, bus.busy}); end
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.resp_ready = 1'b0; bus.req_instr = '0; bus.req_rs1 = '0; bus.req_rs2 = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_abort(2, "reset_exec2");
        test_reset_abort(4, "reset_done");
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
